// File: rtl/clk_seq_pkg.sv
// Shared types, widths and configuration check for the clock-phase sequencer.
package clk_seq_pkg;

    localparam int unsigned DIV_W  = 8;
    localparam int unsigned FCNT_W = 16;
    localparam int unsigned MAX_CH = 8;

    typedef enum logic [1:0] {
        SEQ_HALTED = 2'd0,
        SEQ_RUN    = 2'd1,
        SEQ_STEP   = 2'd2
    } seq_state_e;

    // Elaboration-time sanity check: every ratio >= 2, phase inside its period,
    // and every channel period tiles the channel-0 frame exactly.
    function automatic logic cfg_ok(
        input int unsigned                 num_ch,
        input logic [MAX_CH*DIV_W-1:0]     div_list,
        input logic [MAX_CH*DIV_W-1:0]     ph_list
    );
        logic             ok;
        logic [DIV_W-1:0] div0;
        logic [DIV_W-1:0] div;
        logic [DIV_W-1:0] ph;
        ok   = 1'b1;
        div0 = div_list[DIV_W-1:0];
        if (num_ch < 1 || num_ch > MAX_CH) begin
            ok = 1'b0;
        end
        for (int unsigned i = 0; i < MAX_CH; i++) begin
            if (i < num_ch) begin
                div = div_list[i*DIV_W +: DIV_W];
                ph  = ph_list[i*DIV_W +: DIV_W];
                if (div < DIV_W'(2) || ph >= div) begin
                    ok = 1'b0;
                end else if ((div0 % div) != '0) begin
                    ok = 1'b0;
                end
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/seq_channel.sv
// One sequencer channel: period counter plus registered clock-level and enable decode.
module seq_channel
    import clk_seq_pkg::*;
#(
    parameter logic [DIV_W-1:0] DIV = 8'd2,
    parameter logic [DIV_W-1:0] PH  = 8'd0
) (
    input  logic clock,
    input  logic reset,
    input  logic run_now_i,
    input  logic run_next_i,
    input  logic wrap_i,
    output logic clk_o,
    output logic ce_o
);

    localparam logic [DIV_W-1:0] LAST = DIV - DIV_W'(1);
    localparam logic [DIV_W-1:0] HALF = DIV >> 1;

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] rel;
    logic             clk_q, clk_d;
    logic             ce_q, ce_d;

    // Decode is taken from the next counter value so the flopped outputs line up with it.
    always_comb begin
        cnt_d = '0;
        if (run_now_i && !wrap_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + DIV_W'(1);
        end
        rel   = (cnt_d >= PH) ? cnt_d - PH : DIV - (PH - cnt_d);
        clk_d = run_next_i && (rel < HALF);
        ce_d  = run_next_i && (rel == '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
            clk_q <= 1'b0;
            ce_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            clk_q <= clk_d;
            ce_q  <= ce_d;
        end
    end

    assign clk_o = clk_q;
    assign ce_o  = ce_q;

endmodule

// File: rtl/clk_phase_sequencer.sv
// Multi-channel clock-phase sequencer with frame-boundary halt; single-frame
// stepping is built only when SEQ_STEP_EN is defined.
module clk_phase_sequencer
    import clk_seq_pkg::*;
#(
    parameter int unsigned             NUM_CH   = 4,
    parameter logic [DIV_W*NUM_CH-1:0] DIV_LIST = {8'd2, 8'd2, 8'd4, 8'd4},
    parameter logic [DIV_W*NUM_CH-1:0] PH_LIST  = {8'd1, 8'd0, 8'd2, 8'd0}
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              halt_req,
    input  logic              step,
    output logic [NUM_CH-1:0] clk_o,
    output logic [NUM_CH-1:0] ce_o,
    output logic              frame_start_o,
    output logic              halted_o,
    output logic              step_done_o,
    output logic [FCNT_W-1:0] frame_count_o
);

    localparam int unsigned      CFG_W      = MAX_CH * DIV_W;
    localparam logic [DIV_W-1:0] FRAME_LAST = DIV_LIST[DIV_W-1:0] - DIV_W'(1);

    if (!cfg_ok(NUM_CH, CFG_W'(DIV_LIST), CFG_W'(PH_LIST))) begin : g_cfg_err
        $error("clk_phase_sequencer: invalid DIV_LIST/PH_LIST configuration");
    end

    seq_state_e        state_q, state_d;
    logic [DIV_W-1:0]  pos_q, pos_d;
    logic              frame_start_q, frame_start_d;
    logic              halted_q, halted_d;
    logic              step_done_q, step_done_d;
    logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic              run_now;
    logic              run_next;
    logic              frame_last;

    assign run_now    = (state_q != SEQ_HALTED);
    assign frame_last = run_now && (pos_q == FRAME_LAST);

`ifndef SEQ_STEP_EN
    logic step_unused;
    assign step_unused = step;
`endif

    // Next state, frame position and registered status outputs.
    always_comb begin
        state_d     = state_q;
        step_done_d = 1'b0;
        case (state_q)
            SEQ_HALTED: begin
                if (!halt_req) begin
                    state_d = SEQ_RUN;
                end
`ifdef SEQ_STEP_EN
                else if (step) begin
                    state_d = SEQ_STEP;
                end
`endif
            end
            SEQ_RUN: begin
                if (frame_last && halt_req) begin
                    state_d = SEQ_HALTED;
                end
            end
`ifdef SEQ_STEP_EN
            SEQ_STEP: begin
                if (frame_last) begin
                    state_d     = SEQ_HALTED;
                    step_done_d = 1'b1;
                end
            end
`endif
            default: state_d = SEQ_HALTED;
        endcase

        run_next      = (state_d != SEQ_HALTED);
        pos_d         = (run_now && !frame_last) ? pos_q + DIV_W'(1) : '0;
        frame_start_d = run_next && (pos_d == '0);
        halted_d      = !run_next;
        frame_cnt_d   = frame_last ? frame_cnt_q + FCNT_W'(1) : frame_cnt_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= SEQ_HALTED;
            pos_q         <= '0;
            frame_start_q <= 1'b0;
            halted_q      <= 1'b1;
            step_done_q   <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            pos_q         <= pos_d;
            frame_start_q <= frame_start_d;
            halted_q      <= halted_d;
            step_done_q   <= step_done_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        seq_channel #(
            .DIV (DIV_LIST[i*DIV_W +: DIV_W]),
            .PH  (PH_LIST[i*DIV_W +: DIV_W])
        ) u_ch (
            .clock      (clock),
            .reset      (reset),
            .run_now_i  (run_now),
            .run_next_i (run_next),
            .wrap_i     (frame_last),
            .clk_o      (clk_o[i]),
            .ce_o       (ce_o[i])
        );
    end

    assign frame_start_o = frame_start_q;
    assign halted_o      = halted_q;
    assign step_done_o   = step_done_q;
    assign frame_count_o = frame_cnt_q;

endmodule

// File: tb/tb_clk_phase_sequencer.sv
// Directed, table-driven bench for clk_phase_sequencer (default channel setup).
module tb_clk_phase_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        halt_req;
    logic        step;
    logic [3:0]  clk_o;
    logic [3:0]  ce_o;
    logic        frame_start_o;
    logic        halted_o;
    logic        step_done_o;
    logic [15:0] frame_count_o;

    int errors = 0;
    int checks = 0;

    clk_phase_sequencer #(
        .NUM_CH   (4),
        .DIV_LIST ({8'd2, 8'd2, 8'd4, 8'd4}),
        .PH_LIST  ({8'd1, 8'd0, 8'd2, 8'd0})
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .halt_req      (halt_req),
        .step          (step),
        .clk_o         (clk_o),
        .ce_o          (ce_o),
        .frame_start_o (frame_start_o),
        .halted_o      (halted_o),
        .step_done_o   (step_done_o),
        .frame_count_o (frame_count_o)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        rst;
        logic        hreq;
        logic [3:0]  clk;
        logic [3:0]  ce;
        logic        fs;
        logic        hl;
        logic [15:0] fc;
    } vec_t;

    vec_t vecs [17];

    function automatic vec_t mk(input logic r, input logic h, input logic [3:0] c,
                                input logic [3:0] e, input logic fs, input logic hl,
                                input logic [15:0] fc);
        vec_t v;
        v.rst = r; v.hreq = h; v.clk = c; v.ce = e; v.fs = fs; v.hl = hl; v.fc = fc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled at the next falling edge.
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic chk_out(input string nm, input logic [3:0] c, input logic [3:0] e,
                           input logic fs, input logic hl, input logic sd, input logic [15:0] fc);
        check($sformatf("%s clk_o", nm),         32'(clk_o),         32'(c));
        check($sformatf("%s ce_o", nm),          32'(ce_o),          32'(e));
        check($sformatf("%s frame_start_o", nm), 32'(frame_start_o), 32'(fs));
        check($sformatf("%s halted_o", nm),      32'(halted_o),      32'(hl));
        check($sformatf("%s step_done_o", nm),   32'(step_done_o),   32'(sd));
        check($sformatf("%s frame_count_o", nm), 32'(frame_count_o), 32'(fc));
    endtask

    task automatic wait_halted(input int budget);
        int n;
        n = 0;
        while (!halted_o && n < budget) begin
            tick();
            n++;
        end
        check("halt reached within budget", 32'(halted_o), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] fc_exp;

        // Frame pattern per cnt_0: clk {3,2,1,0} = 5,9,6,A ; ce = 5,8,6,8
        vecs[0]  = mk(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 16'd0);
        vecs[1]  = mk(1'b0, 1'b0, 4'h5, 4'h5, 1'b1, 1'b0, 16'd0);
        vecs[2]  = mk(1'b0, 1'b0, 4'h9, 4'h8, 1'b0, 1'b0, 16'd0);
        vecs[3]  = mk(1'b0, 1'b0, 4'h6, 4'h6, 1'b0, 1'b0, 16'd0);
        vecs[4]  = mk(1'b0, 1'b0, 4'hA, 4'h8, 1'b0, 1'b0, 16'd0);
        vecs[5]  = mk(1'b0, 1'b0, 4'h5, 4'h5, 1'b1, 1'b0, 16'd1);
        vecs[6]  = mk(1'b0, 1'b1, 4'h9, 4'h8, 1'b0, 1'b0, 16'd1);
        vecs[7]  = mk(1'b0, 1'b1, 4'h6, 4'h6, 1'b0, 1'b0, 16'd1);
        vecs[8]  = mk(1'b0, 1'b0, 4'hA, 4'h8, 1'b0, 1'b0, 16'd1);
        vecs[9]  = mk(1'b0, 1'b0, 4'h5, 4'h5, 1'b1, 1'b0, 16'd2);
        vecs[10] = mk(1'b0, 1'b0, 4'h9, 4'h8, 1'b0, 1'b0, 16'd2);
        vecs[11] = mk(1'b0, 1'b1, 4'h6, 4'h6, 1'b0, 1'b0, 16'd2);
        vecs[12] = mk(1'b0, 1'b1, 4'hA, 4'h8, 1'b0, 1'b0, 16'd2);
        vecs[13] = mk(1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 16'd3);
        vecs[14] = mk(1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 16'd3);
        vecs[15] = mk(1'b0, 1'b0, 4'h5, 4'h5, 1'b1, 1'b0, 16'd3);
        vecs[16] = mk(1'b0, 1'b0, 4'h9, 4'h8, 1'b0, 1'b0, 16'd3);

        reset    = 1'b1;
        halt_req = 1'b0;
        step     = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 17; i++) begin
            reset    = vecs[i].rst;
            halt_req = vecs[i].hreq;
            tick();
            chk_out($sformatf("vec%0d", i), vecs[i].clk, vecs[i].ce, vecs[i].fs,
                    vecs[i].hl, 1'b0, vecs[i].fc);
        end

        // Halt requested at cnt_0=1 stops after cnt_0=3.
        halt_req = 1'b1;
        wait_halted(8);
        tick();
        chk_out("halted frozen", 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 16'd4);

`ifdef SEQ_STEP_EN
        step = 1'b1; tick(); step = 1'b0;
        chk_out("step c1", 4'h5, 4'h5, 1'b1, 1'b0, 1'b0, 16'd4);
        step = 1'b1; tick(); step = 1'b0;
        chk_out("step c2", 4'h9, 4'h8, 1'b0, 1'b0, 1'b0, 16'd4);
        tick();
        chk_out("step c3", 4'h6, 4'h6, 1'b0, 1'b0, 1'b0, 16'd4);
        tick();
        chk_out("step c4", 4'hA, 4'h8, 1'b0, 1'b0, 1'b0, 16'd4);
        tick();
        chk_out("step done", 4'h0, 4'h0, 1'b0, 1'b1, 1'b1, 16'd5);
        tick();
        chk_out("step after", 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 16'd5);

        // Step, then drop halt_req mid-step: frame still ends, then RUN resumes.
        step = 1'b1; tick(); step = 1'b0; halt_req = 1'b0;
        chk_out("step2 c1", 4'h5, 4'h5, 1'b1, 1'b0, 1'b0, 16'd5);
        tick();
        chk_out("step2 c2", 4'h9, 4'h8, 1'b0, 1'b0, 1'b0, 16'd5);
        tick(); tick();
        chk_out("step2 c4", 4'hA, 4'h8, 1'b0, 1'b0, 1'b0, 16'd5);
        tick();
        chk_out("step2 done", 4'h0, 4'h0, 1'b0, 1'b1, 1'b1, 16'd6);
        tick();
        chk_out("step2 run", 4'h5, 4'h5, 1'b1, 1'b0, 1'b0, 16'd6);
        halt_req = 1'b1;
        wait_halted(8);
        fc_exp = 16'd7;
`else
        step = 1'b1; tick(); step = 1'b0;
        chk_out("nostep pulse", 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 16'd4);
        repeat (5) tick();
        chk_out("nostep hold", 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 16'd4);
        fc_exp = 16'd4;
`endif
        check("halted before drop+step", 32'(frame_count_o), 32'(fc_exp));

        // halt_req dropped together with step: RUN wins, no step_done_o, no stop.
        halt_req = 1'b0; step = 1'b1; tick(); step = 1'b0;
        chk_out("drop+step c1", 4'h5, 4'h5, 1'b1, 1'b0, 1'b0, fc_exp);
        tick(); tick(); tick();
        chk_out("drop+step c4", 4'hA, 4'h8, 1'b0, 1'b0, 1'b0, fc_exp);
        tick();
        chk_out("drop+step next", 4'h5, 4'h5, 1'b1, 1'b0, 1'b0, fc_exp + 16'd1);
        tick(); tick();
        chk_out("pre reset cnt2", 4'h6, 4'h6, 1'b0, 1'b0, 1'b0, fc_exp + 16'd1);

        // Reset at cnt_0=2 in RUN.
        reset = 1'b1; halt_req = 1'b1; tick();
        chk_out("reset mid-frame", 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 16'd0);
        reset = 1'b0; tick();
        chk_out("reset hold", 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 16'd0);

        // Preload the frame counter near its top while halted, then run two frames.
        force dut.frame_cnt_q = 16'hFFFE;
        tick(); tick();
        release dut.frame_cnt_q;
        tick();
        chk_out("preload", 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 16'hFFFE);
        halt_req = 1'b0; tick();
        chk_out("wrap f0", 4'h5, 4'h5, 1'b1, 1'b0, 1'b0, 16'hFFFE);
        repeat (4) tick();
        chk_out("wrap f1", 4'h5, 4'h5, 1'b1, 1'b0, 1'b0, 16'hFFFF);
        repeat (4) tick();
        chk_out("wrap f2", 4'h5, 4'h5, 1'b1, 1'b0, 1'b0, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
